vedic_mult_arbiter: RTL and testbench

//  Shares one pipelined 8x8 Vedic multiplier between two requesters. Round-robin

---
 rtl/vedic_pkg.sv | 22 ++
 rtl/vedic_tag_pipe.sv | 38 +++
 rtl/vedic_mult_arbiter.sv | 155 +++++++++++++++
 tb/tb_vedic_mult_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared definitions for the Vedic multiplier arbiter: default sizes,
// control-state encoding and the {valid,id} tag carried alongside each product.
package vedic_pkg;

    localparam int VEDIC_W       = 8;
    localparam int VEDIC_MUL_LAT = 3;
    localparam int VEDIC_PW      = 2 * VEDIC_W;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/vedic_tag_pipe.sv
// Fixed-depth, never-stalling shift register that carries the requester tag
// of each issued operation in lockstep with the multiplier pipeline.
module vedic_tag_pipe
    import vedic_pkg::*;
#(
    parameter int DEPTH = VEDIC_MUL_LAT + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage_q [DEPTH];
    tag_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // NOTE: this storage array is reset on purpose; a stale valid bit would emit a
    // phantom response after reset, so every stage must start empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/vedic_mult_arbiter.sv
// Round-robin front end that shares one pipelined multiplier between two
// requesters, routes products back by tag, and supports flush/drain.
module vedic_mult_arbiter
    import vedic_pkg::*;
#(
    parameter int MUL_LAT = VEDIC_MUL_LAT,
    parameter int W       = VEDIC_W
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           REQ0_VALID,
    input  logic [W-1:0]   REQ0_A,
    input  logic [W-1:0]   REQ0_B,
    output logic           REQ0_READY,
    input  logic           REQ1_VALID,
    input  logic [W-1:0]   REQ1_A,
    input  logic [W-1:0]   REQ1_B,
    output logic           REQ1_READY,
    output logic           RSP0_VALID,
    output logic [2*W-1:0] RSP0_P,
    output logic           RSP1_VALID,
    output logic [2*W-1:0] RSP1_P,
    output logic [W-1:0]   MUL_A,
    output logic [W-1:0]   MUL_B,
    output logic           MUL_VALID,
    input  logic [2*W-1:0] MUL_P,
    input  logic           FLUSH,
    output logic           FLUSH_DONE,
    output logic           BUSY
);

    localparam int CW = $clog2(MUL_LAT + 2);

    state_e          state_q, state_d;
    req_id_t         prio_q, prio_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W-1:0]    mul_a_q, mul_a_d;
    logic [W-1:0]    mul_b_q, mul_b_d;
    logic            mul_valid_q, mul_valid_d;
    logic            rsp0_valid_q, rsp0_valid_d;
    logic            rsp1_valid_q, rsp1_valid_d;
    logic [2*W-1:0]  rsp0_p_q, rsp0_p_d;
    logic [2*W-1:0]  rsp1_p_q, rsp1_p_d;

    req_id_t winner;
    logic    accept;
    tag_t    tag_in;
    tag_t    tag_out;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        winner     = prio_q;
        if (state_q == RUN && !FLUSH) begin
            if (REQ0_VALID && REQ1_VALID) begin
                winner = prio_q;
            end else begin
                winner = REQ1_VALID;
            end
            REQ0_READY = REQ0_VALID && (winner == 1'b0);
            REQ1_READY = REQ1_VALID && (winner == 1'b1);
        end
        accept = REQ0_READY || REQ1_READY;
    end

    assign tag_in.valid = accept;
    assign tag_in.id    = winner;

    vedic_tag_pipe #(
        .DEPTH (MUL_LAT + 1)
    ) u_tag_pipe (
        .clk     (CLK),
        .rst_n   (RST_N),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    always_comb begin
        prio_d      = accept ? ~winner : prio_q;
        mul_valid_d = accept;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        if (accept) begin
            mul_a_d = winner ? REQ1_A : REQ0_A;
            mul_b_d = winner ? REQ1_B : REQ0_B;
        end

        // The tag leaving the pipe lines up with the product currently on MUL_P.
        rsp0_valid_d = tag_out.valid && (tag_out.id == 1'b0);
        rsp1_valid_d = tag_out.valid && (tag_out.id == 1'b1);
        rsp0_p_d     = rsp0_valid_d ? MUL_P : rsp0_p_q;
        rsp1_p_d     = rsp1_valid_d ? MUL_P : rsp1_p_q;

        case ({accept, tag_out.valid})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        state_d = state_q;
        case (state_q)
            RUN: begin
                if (FLUSH) state_d = DRAIN;
            end
            DRAIN: begin
                if (!FLUSH)              state_d = RUN;
                else if (count_q == '0)  state_d = DONE;
            end
            DONE: begin
                if (!FLUSH) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update
    // from the same pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= RUN;
            prio_q       <= 1'b0;
            count_q      <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_valid_q  <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_p_q     <= '0;
            rsp1_p_q     <= '0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            count_q      <= count_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_valid_q  <= mul_valid_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_p_q     <= rsp0_p_d;
            rsp1_p_q     <= rsp1_p_d;
        end
    end

    assign MUL_A      = mul_a_q;
    assign MUL_B      = mul_b_q;
    assign MUL_VALID  = mul_valid_q;
    assign RSP0_VALID = rsp0_valid_q;
    assign RSP1_VALID = rsp1_valid_q;
    assign RSP0_P     = rsp0_p_q;
    assign RSP1_P     = rsp1_p_q;
    assign BUSY       = (count_q != '0);
    assign FLUSH_DONE = (state_q == DONE);

endmodule

// File: tb/tb_vedic_mult_arbiter.sv
// Directed bench for vedic_mult_arbiter with a behavioural 3-stage multiplier
// on the MUL_* side and hand-computed expected values.
module tb_vedic_mult_arbiter;

    localparam int W       = 8;
    localparam int PW      = 2 * W;
    localparam int MUL_LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp1_valid;
    logic [PW-1:0] rsp0_p, rsp1_p;
    logic [W-1:0]  mul_a, mul_b;
    logic          mul_valid;
    logic [PW-1:0] mul_p;
    logic          flush, flush_done, busy;

    int n_checks = 0;
    int n_fail   = 0;

    int burst_cnt [10] = '{1, 2, 3, 4, 4, 4, 3, 2, 1, 0};

    int            errs, seen, q;
    logic [W-1:0]  qa, qb, pa, pb;
    logic [PW-1:0] qprod;

    always #5 clk = ~clk;

    vedic_mult_arbiter #(
        .MUL_LAT (MUL_LAT),
        .W       (W)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .REQ0_VALID (req0_valid),
        .REQ0_A     (req0_a),
        .REQ0_B     (req0_b),
        .REQ0_READY (req0_ready),
        .REQ1_VALID (req1_valid),
        .REQ1_A     (req1_a),
        .REQ1_B     (req1_b),
        .REQ1_READY (req1_ready),
        .RSP0_VALID (rsp0_valid),
        .RSP0_P     (rsp0_p),
        .RSP1_VALID (rsp1_valid),
        .RSP1_P     (rsp1_p),
        .MUL_A      (mul_a),
        .MUL_B      (mul_b),
        .MUL_VALID  (mul_valid),
        .MUL_P      (mul_p),
        .FLUSH      (flush),
        .FLUSH_DONE (flush_done),
        .BUSY       (busy)
    );

    // Multiplier core stand-in: product visible MUL_LAT edges after issue.
    logic [PW-1:0] mul_pipe [MUL_LAT];
    always @(posedge clk) begin
        mul_pipe[0] <= PW'(mul_a) * PW'(mul_b);
        for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
    assign mul_p = mul_pipe[MUL_LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;

        // Reset state
        #2;
        check("rst_mul_valid", mul_valid, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_rsp0_p", rsp0_p, 0);
        check("rst_busy", busy, 0);
        check("rst_flush_done", flush_done, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Both requesters valid every cycle: grants alternate 0,1,0,1
        req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd5;
        req1_valid = 1'b1; req1_a = 8'd7; req1_b = 8'd9;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ready0", req0_ready, (i % 2 == 0));
            check("rr_ready1", req1_ready, (i % 2 == 1));
            tick();
            check("rr_mul_a", mul_a, (i % 2 == 0) ? 3 : 7);
            check("rr_mul_valid", mul_valid, 1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_rsp0_valid", rsp0_valid, (i % 2 == 0));
            check("rr_rsp1_valid", rsp1_valid, (i % 2 == 1));
            check("rr_rsp0_p", rsp0_p, 15);
            if (i % 2 == 1) check("rr_rsp1_p", rsp1_p, 63);
        end
        tick();
        check("rr_busy_idle", busy, 0);

        // Single requester FF*FF
        req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF;
        #1;
        check("single_ready0", req0_ready, 1);
        check("single_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        check("single_mul_b", mul_b, 8'hFF);
        check("single_busy", busy, 1);
        tick(); tick(); tick();
        check("single_rsp0_early", rsp0_valid, 0);
        tick();
        check("single_rsp0_valid", rsp0_valid, 1);
        check("single_rsp0_p", rsp0_p, 16'hFE01);
        check("single_rsp1_valid", rsp1_valid, 0);
        tick();
        check("single_rsp0_pulse", rsp0_valid, 0);
        check("single_rsp0_hold", rsp0_p, 16'hFE01);
        check("single_busy_done", busy, 0);

        // Burst of 6 back-to-back requests on requester 1
        for (int c = 0; c < 10; c++) begin
            if (c < 6) begin
                req1_valid = 1'b1;
                req1_a = 8'(c + 1);
                req1_b = 8'(c + 2);
                #1;
                check("burst_ready1", req1_ready, 1);
            end else begin
                req1_valid = 1'b0;
            end
            tick();
            check("burst_count", dut.count_q, burst_cnt[c]);
            check("burst_busy", busy, (burst_cnt[c] != 0));
            check("burst_rsp1_valid", rsp1_valid, (c >= 4));
            check("burst_rsp0_valid", rsp0_valid, 0);
            if (c >= 4) check("burst_rsp1_p", rsp1_p, (c - 3) * (c - 2));
        end

        // Flush with three operations in flight
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1;
            req0_a = 8'(10 + i);
            req0_b = 8'd2;
            tick();
        end
        req0_a = 8'd99;
        flush = 1'b1;
        #1;
        check("flush_ready_low", req0_ready, 0);
        for (int c = 3; c < 8; c++) begin
            tick();
            check("flush_ready0", req0_ready, 0);
            check("flush_mul_valid", mul_valid, 0);
            check("flush_rsp0_valid", rsp0_valid, (c >= 4 && c <= 6));
            if (c >= 4 && c <= 6) check("flush_rsp0_p", rsp0_p, (10 + c - 4) * 2);
            check("flush_busy", busy, (c < 6));
            check("flush_done", flush_done, (c == 7));
        end
        flush = 1'b0;
        #1;
        check("done_ready_low", req0_ready, 0);
        tick();
        check("run_ready_back", req0_ready, 1);
        check("run_flush_done", flush_done, 0);
        req0_valid = 1'b0;
        tick();

        // Asynchronous reset with two operations in flight
        req1_valid = 1'b1; req1_a = 8'd5; req1_b = 8'd6;
        tick();
        req1_a = 8'd7; req1_b = 8'd8;
        tick();
        req1_valid = 1'b0;
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_mul_valid", mul_valid, 0);
        check("async_mul_a", mul_a, 0);
        check("async_busy", busy, 0);
        check("async_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        check("async_rsp1_p", rsp1_p, 0);
        check("async_ready", {req0_ready, req1_ready}, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_no_rsp", {rsp0_valid, rsp1_valid}, 0);
        end
        req0_valid = 1'b1; req0_a = 8'd12; req0_b = 8'd13;
        #1;
        check("post_rst_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        tick(); tick(); tick();
        check("post_rst_rsp_early", rsp0_valid, 0);
        tick();
        check("post_rst_rsp0_valid", rsp0_valid, 1);
        check("post_rst_rsp0_p", rsp0_p, 156);

        // Exhaustive operand sweep, alternating requesters each cycle
        errs = 0;
        seen = 0;
        for (int p = 0; p < 65536 + MUL_LAT + 1; p++) begin
            if (p < 65536) begin
                pa = p[15:8];
                pb = p[7:0];
                req0_valid = ~p[0];
                req1_valid = p[0];
                req0_a = pa; req0_b = pb;
                req1_a = pa; req1_b = pb;
                #1;
                if ((p[0] ? req1_ready : req0_ready) !== 1'b1) errs++;
            end else begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            tick();
            if (p >= MUL_LAT + 1) begin
                q     = p - (MUL_LAT + 1);
                qa    = q[15:8];
                qb    = q[7:0];
                qprod = PW'(qa) * PW'(qb);
                if (q[0]) begin
                    if (rsp1_valid === 1'b1 && rsp0_valid === 1'b0 && rsp1_p === qprod) seen++;
                    else errs++;
                end else begin
                    if (rsp0_valid === 1'b1 && rsp1_valid === 1'b0 && rsp0_p === qprod) seen++;
                    else errs++;
                end
            end
        end
        check("sweep_errors", errs, 0);
        check("sweep_responses", seen, 65536);
        tick();
        check("sweep_busy_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
